// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Single-approach traffic light controller. The light rests in RED until a
// vehicle waits at the stop line (sensor_1th) and the minimum red time has
// elapsed. GREEN then runs a fixed short phase, or a long phase if the queue
// reaches the 5th-car position (sensor_5th) at any point while green. YELLOW
// follows for a fixed time and the controller returns to RED.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset (forces RED)
//   sensor_1th  in   vehicle present at stop line, synchronous to clk
//   sensor_5th  in   queue reaches the 5th car, synchronous to clk
//   light       out  registered lamp code: 00 RED, 01 GREEN, 10 YELLOW
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int CNT_W       = 8,
    parameter int RED_MIN     = 10,
    parameter int GREEN_SHORT = 8,
    parameter int GREEN_LONG  = 16,
    parameter int YELLOW_TIME = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_1th,
    input  logic       sensor_5th,
    output logic [1:0] light
);

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } state_t;

    // Last cycle index of each phase, in counter width.
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_MIN - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(GREEN_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(GREEN_LONG - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ext;
    logic             ext_next;
    logic             ext_seen;
    logic [CNT_W-1:0] green_last;
    logic [1:0]       light_next;

    // State, phase counter, long-green flag and lamp register. Reset drops
    // everything back to the start of a fresh RED phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RED;
            cnt   <= '0;
            ext   <= 1'b0;
            light <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ext   <= ext_next;
            light <= light_next;
        end
    end

    // Next-state logic. The defaults describe a fresh RED phase, which is
    // also where an illegal state encoding lands. The counter restarts at 0
    // on every phase change and otherwise counts cycles spent in the phase.
    always_comb begin
        state_next = RED;
        cnt_next   = '0;
        ext_next   = 1'b0;
        ext_seen   = 1'b0;
        green_last = SHORT_LAST;

        case (state)
            RED: begin
                // Once the minimum red time is used up the counter parks at
                // its last value, so a late request leaves on the next edge.
                if (cnt == RED_LAST) begin
                    if (sensor_1th) begin
                        state_next = GREEN;
                    end else begin
                        state_next = RED;
                        cnt_next   = cnt;
                    end
                end else begin
                    state_next = RED;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end

            GREEN: begin
                // A long queue seen on the current cycle already counts, so a
                // sighting on the short deadline cycle still extends the phase.
                ext_seen   = ext | sensor_5th;
                green_last = ext_seen ? LONG_LAST : SHORT_LAST;
                if (cnt == green_last) begin
                    state_next = YELLOW;
                end else begin
                    state_next = GREEN;
                    cnt_next   = cnt + CNT_W'(1);
                    ext_next   = ext_seen;
                end
            end

            YELLOW: begin
                if (cnt == YELLOW_LAST) begin
                    state_next = RED;
                end else begin
                    state_next = YELLOW;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = RED;
            end
        endcase
    end

    // The lamp register follows the next state, so light always equals the
    // encoding of the current state and never depends on the sensors directly.
    always_comb begin
        light_next = 2'b00;
        case (state_next)
            GREEN:   light_next = 2'b01;
            YELLOW:  light_next = 2'b10;
            default: light_next = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Directed bench for traffic_light_ctrl. Each stimulus cycle drives the
// inputs and queues the lamp code expected during that cycle; a monitor on
// the falling edge pops the queue and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_GREEN  = 2'b01;
    localparam logic [1:0] L_YELLOW = 2'b10;

    typedef struct {
        logic [1:0] light;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sensor_1th;
    logic       sensor_5th;
    logic [1:0] light;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    traffic_light_ctrl #(
        .CNT_W       (8),
        .RED_MIN     (10),
        .GREEN_SHORT (8),
        .GREEN_LONG  (16),
        .YELLOW_TIME (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_1th (sensor_1th),
        .sensor_5th (sensor_5th),
        .light      (light)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one input pattern for n cycles, queueing the lamp code that must
    // be visible during each of those cycles. Inputs change 1 time unit after
    // the rising edge, so an asserted rst is seen before the next clock edge.
    task automatic applyStimulus(input logic r, input logic s1, input logic s5,
                                 input logic [1:0] exp_light, input int n,
                                 input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst        = r;
            sensor_1th = s1;
            sensor_5th = s5;
            e.light    = exp_light;
            e.tag      = tag;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if (light !== e.light) begin
            n_errors++;
            $display("[TB] FAIL %s (check %0d, t=%0t): light=%b expected %b",
                     e.tag, n_checks, $time, light, e.light);
        end
    endtask

    // Monitor: one expected value per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        sensor_1th = 1'b0;
        sensor_5th = 1'b0;
        @(posedge clk);
        #1;

        // Reset and idle RED.
        applyStimulus(1, 0, 0, L_RED, 2, "reset");
        applyStimulus(0, 0, 0, L_RED, 20, "idle_red");

        // Basic cycle: late request leaves RED on the next edge, then a short
        // green, yellow, and a 10-cycle red with the request held.
        applyStimulus(0, 1, 0, L_RED,    1,  "basic_request");
        applyStimulus(0, 1, 0, L_GREEN,  8,  "basic_green");
        applyStimulus(0, 1, 0, L_YELLOW, 3,  "basic_yellow");
        applyStimulus(0, 1, 0, L_RED,    10, "basic_red_min");
        applyStimulus(0, 1, 0, L_GREEN,  8,  "basic_green2");
        applyStimulus(0, 1, 0, L_YELLOW, 3,  "basic_yellow2");
        applyStimulus(0, 1, 0, L_RED,    10, "basic_red2");

        // Long green with both sensors held: 29-cycle period.
        applyStimulus(0, 1, 1, L_GREEN,  16, "long_green");
        applyStimulus(0, 1, 1, L_YELLOW, 3,  "long_yellow");
        applyStimulus(0, 1, 1, L_RED,    10, "long_red");
        applyStimulus(0, 1, 1, L_GREEN,  16, "long_green2");
        applyStimulus(0, 1, 1, L_YELLOW, 3,  "long_yellow2");

        // Single-cycle sensor_5th pulse at GREEN cycle 3, then both sensors
        // drop: green still runs 16 cycles and RED then holds.
        applyStimulus(0, 1, 0, L_RED,    10, "pulse_red");
        applyStimulus(0, 1, 0, L_GREEN,  3,  "pulse_green_pre");
        applyStimulus(0, 1, 1, L_GREEN,  1,  "pulse_green_hit");
        applyStimulus(0, 0, 0, L_GREEN,  12, "pulse_green_post");
        applyStimulus(0, 0, 0, L_YELLOW, 3,  "drop_yellow");
        applyStimulus(0, 0, 0, L_RED,    15, "drop_red_hold");

        // Early request at RED cycle 2 must still wait for RED_MIN.
        applyStimulus(0, 1, 0, L_RED,    1,  "early_setup_go");
        applyStimulus(0, 0, 0, L_GREEN,  8,  "early_setup_green");
        applyStimulus(0, 0, 0, L_YELLOW, 3,  "early_setup_yellow");
        applyStimulus(0, 0, 0, L_RED,    2,  "early_red_idle");
        applyStimulus(0, 1, 0, L_RED,    8,  "early_red_wait");
        applyStimulus(0, 1, 1, L_GREEN,  3,  "early_green_ext");

        // Reset mid-GREEN (extension already latched): lamp drops at once,
        // then a full red precedes a short green, so ext was discarded.
        applyStimulus(1, 1, 0, L_RED,    2,  "midreset");
        applyStimulus(0, 1, 0, L_RED,    10, "postreset_red");
        applyStimulus(0, 1, 0, L_GREEN,  8,  "postreset_green");
        applyStimulus(0, 1, 0, L_YELLOW, 3,  "postreset_yellow");

        // sensor_5th alone never leaves RED.
        applyStimulus(0, 0, 1, L_RED,    20, "red_5th_only");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL drain: %0d expected values left, required 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
